// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Arbitrates two requesters onto one single-port synchronous SRAM.
//   At most one access per cycle is granted, with no bubbles between accesses.
//   A read granted in cycle N returns sram_q to its owner in cycle N+1 as a
//   one-cycle rvalid pulse. Writes complete in the grant cycle and return
//   nothing.
//
//   Build option:
//     SRAM_ARB_ROUND_ROBIN_EN  defined   -> on contention the requester not
//                                          granted most recently wins.
//                              undefined -> fixed priority, m0 always wins.
//
//   Handshake: mX_req is a level held until mX_gnt. mX_gnt is combinational
//   and means "accepted this cycle"; the requester may change its request on
//   the next cycle.
//
//   Ports
//     CLK, RST             clock, synchronous active-high reset
//     mX_req/we/addr/wdata requester X access request (X = 0, 1)
//     mX_gnt               requester X accepted this cycle
//     mX_rvalid/rdata      read return for requester X
//     sram_cen/wen         SRAM chip/write enable, active-low
//     sram_a/sram_d        SRAM address and write data
//     sram_q               SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    logic w_pick_m0;   // m0 wins arbitration (before reset gating)
    logic w_gnt_m0;
    logic w_gnt_m1;
    logic w_any_gnt;
    logic w_sel_we;    // write flag of the granted requester
    logic w_rd_accept; // a read is being issued to the SRAM this cycle

    // Read-return tracking: one outstanding read at most, since the SRAM
    // answers in exactly one cycle. A new read can be issued while the
    // previous one returns, which gives full back-to-back throughput.
    logic r_pend;
    logic r_owner;     // 0 = m0, 1 = m1

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = m1 was granted most recently. Reset to m1 so m0 wins first.
    logic r_last_m1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_m1 <= 1'b1;
        end else if (w_any_gnt) begin
            r_last_m1 <= w_gnt_m1;
        end
    end

    assign w_pick_m0 = m0_req && (!m1_req || r_last_m1);
`else
    assign w_pick_m0 = m0_req;
`endif

    // Grants are suppressed while in reset so nothing reaches the SRAM and
    // no read can be recorded as pending.
    assign w_gnt_m0  = w_pick_m0 && !RST;
    assign w_gnt_m1  = m1_req && !w_pick_m0 && !RST;
    assign w_any_gnt = w_gnt_m0 || w_gnt_m1;

    assign m0_gnt = w_gnt_m0;
    assign m1_gnt = w_gnt_m1;

    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = m0_addr;
        sram_d   = m0_wdata;
        w_sel_we = m0_we;
        if (w_gnt_m1) begin
            sram_a   = m1_addr;
            sram_d   = m1_wdata;
            w_sel_we = m1_we;
        end
        if (w_any_gnt) begin
            sram_cen = 1'b0;
            sram_wen = ~w_sel_we;
        end
    end

    assign w_rd_accept = w_any_gnt && !w_sel_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend  <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_pend  <= w_rd_accept;
            r_owner <= w_gnt_m1;
        end
    end

    // Gating with RST kills a return that was registered just before reset
    // was asserted: a read granted in the cycle before reset never reports.
    assign m0_rvalid = r_pend && !r_owner && !RST;
    assign m1_rvalid = r_pend &&  r_owner && !RST;
    assign m0_rdata  = sram_q;
    assign m1_rdata  = sram_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a behavioural SRAM model. The driver
//   checks grants and SRAM control in the issue cycle and queues the expected
//   read return ({cycle, owner, data}); a monitor pops and compares whenever
//   an rvalid appears.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [15:0] cyc = 16'd0;
    always @(posedge CLK) cyc <= cyc + 16'd1;

    // ---------------- DUT ----------------
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    // ---------------- SRAM model (with bench preload port) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [48:0] exp_q[$];   // {cycle[15:0], owner, data[31:0]}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin
        logic [48:0] e;
        while (exp_q.size() > 0 && exp_q[0][48:33] < cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL rvalid_missing: got none expected owner %0d data %0h at cycle %0d",
                     e[32], e[31:0], e[48:33]);
        end
        if (m0_rvalid || m1_rvalid) begin
            check("rvalid_onehot", 64'(m0_rvalid && m1_rvalid), 64'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rvalid_unexpected: got m0=%0d m1=%0d expected none (cycle %0d)",
                         m0_rvalid, m1_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_cycle", 64'(cyc), 64'(e[48:33]));
                check("rvalid_owner", 64'(m1_rvalid), 64'(e[32]));
                check("rdata", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLK); #1;
        pl_en = 1'b0;
    endtask

    // One cycle of stimulus. e0/e1 are the expected grants; a granted read
    // with push=1 queues rd_exp for the owner one cycle later.
    task automatic acc(input string tag,
                       input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic e0, input logic e1, input logic push, input logic [DW-1:0] rd_exp);
        logic sel_we;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(negedge CLK);
        check({tag, "_gnt0"}, 64'(m0_gnt), 64'(e0));
        check({tag, "_gnt1"}, 64'(m1_gnt), 64'(e1));
        check({tag, "_cen"}, 64'(sram_cen), 64'(!(e0 || e1)));
        sel_we = e1 ? w1 : w0;
        if (e0 || e1) begin
            check({tag, "_wen"}, 64'(sram_wen), 64'(!sel_we));
            check({tag, "_addr"}, 64'(sram_a), 64'(e1 ? a1 : a0));
            check({tag, "_wdata"}, 64'(sram_d), 64'(e1 ? d1 : d0));
            if (push && !sel_we) exp_q.push_back({cyc + 16'd1, e1, rd_exp});
        end else begin
            check({tag, "_wen"}, 64'(sram_wen), 64'd1);
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle(input string tag);
        acc(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        @(posedge CLK); #1;
        preload(10'h005, 32'hDEADBEEF);
        preload(10'h010, 32'hA5A50010);
        preload(10'h020, 32'h5A5A0020);
        preload(10'h030, 32'hC0DE0030);
        preload(10'h031, 32'hC0DE0031);

        // Reset holds everything quiet even with both requests up.
        acc("rst", 1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, 1'b1, '0);
        check("rst_rvalid0", 64'(m0_rvalid), 64'd0);
        check("rst_rvalid1", 64'(m1_rvalid), 64'd0);
        RST = 1'b0;

        // Contention, writes, first cycles after reset.
        for (int i = 0; i < 4; i++) begin
            acc("cont_wr", 1'b1, 1'b1, 10'h100, 32'h11111111, 1'b1, 1'b1, 10'h101, 32'h22222222,
                RR ? (i % 2 == 0) : 1'b1, RR ? (i % 2 == 1) : 1'b0, 1'b1, '0);
        end
        // Contention, reads: owner of each return follows the grant.
        acc("cont_rd", 1'b1, 1'b0, 10'h030, '0, 1'b1, 1'b0, 10'h031, '0,
            1'b1, 1'b0, 1'b1, 32'hC0DE0030);
        acc("cont_rd", 1'b1, 1'b0, 10'h030, '0, 1'b1, 1'b0, 10'h031, '0,
            !RR, RR, 1'b1, RR ? 32'hC0DE0031 : 32'hC0DE0030);

        for (int i = 0; i < 10; i++) idle("idle");

        // Single read by m0.
        acc("rd_m0", 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        idle("idle");

        // m1 write then readback at the top address.
        acc("wr_m1", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 1'b1, 1'b1, '0);
        acc("rd_m1", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0, 1'b0, 1'b1, 1'b1, 32'h12345678);
        idle("idle");

        // Back-to-back mixed owners, then a write slipped between reads.
        acc("b2b_m0", 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 32'hA5A50010);
        acc("b2b_m1", 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h020, '0, 1'b0, 1'b1, 1'b1, 32'h5A5A0020);
        acc("b2b_m0", 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        acc("b2b_wr", 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h010, 32'hFEEDF00D, 1'b0, 1'b1, 1'b1, '0);
        acc("b2b_m0", 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 32'hFEEDF00D);
        idle("idle");

        // Reset in the cycle after a read grant: that read never returns.
        acc("rst_mid_rd", 1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            acc("rst_mid", 1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h020, '0, 1'b0, 1'b0, 1'b1, '0);
        end
        RST = 1'b0;
        acc("post_rst", 1'b1, 1'b1, 10'h200, 32'h0A0A0A0A, 1'b1, 1'b1, 10'h201, 32'h0B0B0B0B,
            1'b1, 1'b0, 1'b1, '0);
        acc("post_rst", 1'b1, 1'b1, 10'h200, 32'h0A0A0A0A, 1'b1, 1'b1, 10'h201, 32'h0B0B0B0B,
            !RR, RR, 1'b1, '0);

        for (int i = 0; i < 3; i++) idle("idle");
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
